// File: rtl/uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                               |
// | Description : Round-robin arbiter that shares one RS232 TX FIFO write port  |
// |               between NUM_REQ byte-stream requesters. A grant is held for a |
// |               whole line/burst (EOL byte, MAX_BURST bytes or idle timeout). |
// |               Optional per-burst source tag: define UART_TX_ARB_TAG_EN.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module uart_tx_arbiter #(
   parameter int         NUM_REQ      = 2,
   parameter int         MAX_BURST    = 64,
   parameter int         IDLE_TIMEOUT = 255,
   parameter logic [7:0] EOL_CHAR     = 8'h0A,
   parameter logic [7:0] TAG_BASE     = 8'h30
) (
   input  logic                   ACLK,
   input  logic                   RESET_N,
   input  logic [NUM_REQ-1:0]     REQ_VALID,
   input  logic [8*NUM_REQ-1:0]   REQ_DATA,
   output logic [NUM_REQ-1:0]     REQ_READY,
   output logic [NUM_REQ-1:0]     GRANT,
   output logic                   BUSY,
   output logic                   TX_WRSTB,
   output logic [7:0]             TX_DATA,
   input  logic                   TX_FULL
);

   localparam int c_PTR_W  = $clog2(NUM_REQ);
   localparam int c_BCNT_W = $clog2(MAX_BURST + 1);
   localparam int c_ICNT_W = $clog2(IDLE_TIMEOUT + 1);

   localparam logic [c_PTR_W-1:0]  c_PTR_LAST   = c_PTR_W'(NUM_REQ - 1);
   localparam logic [c_PTR_W-1:0]  c_PTR_ONE    = c_PTR_W'(1);
   localparam logic [c_BCNT_W-1:0] c_BURST_LAST = c_BCNT_W'(MAX_BURST - 1);
   localparam logic [c_BCNT_W-1:0] c_BCNT_ONE   = c_BCNT_W'(1);
   localparam logic [c_ICNT_W-1:0] c_IDLE_LAST  = c_ICNT_W'(IDLE_TIMEOUT - 1);
   localparam logic [c_ICNT_W-1:0] c_ICNT_ONE   = c_ICNT_W'(1);
   localparam logic [NUM_REQ-1:0]  c_GRANT_LSB  = NUM_REQ'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TAG  = 2'd1,
      S_XFER = 2'd2
   } state_t;

   state_t               r_state,     w_state_nxt;
   logic [c_PTR_W-1:0]   r_owner,     w_owner_nxt;
   logic [c_PTR_W-1:0]   r_rr_ptr,    w_rr_ptr_nxt;
   logic [NUM_REQ-1:0]   r_grant,     w_grant_nxt;
   logic [c_BCNT_W-1:0]  r_burst_cnt, w_burst_cnt_nxt;
   logic [c_ICNT_W-1:0]  r_idle_cnt,  w_idle_cnt_nxt;
   logic                 r_tx_wrstb,  w_tx_wrstb_nxt;
   logic [7:0]           r_tx_data,   w_tx_data_nxt;

   logic [c_PTR_W-1:0]   w_pick;
   logic [c_PTR_W-1:0]   w_pick_hi;
   logic [c_PTR_W-1:0]   w_pick_lo;
   logic                 w_found_hi;
   logic                 w_owner_valid;
   logic [7:0]           w_owner_data;
   logic [c_PTR_W-1:0]   w_owner_inc;
   logic                 w_accept;

   // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid index overall
   always_comb begin
      w_pick_hi  = '0;
      w_pick_lo  = '0;
      w_found_hi = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (REQ_VALID[i]) begin
            w_pick_lo = c_PTR_W'(i);
            if (c_PTR_W'(i) >= r_rr_ptr) begin
               w_pick_hi  = c_PTR_W'(i);
               w_found_hi = 1'b1;
            end
         end
      end
      w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
   end

   // Select the current owner's valid flag and byte
   always_comb begin
      w_owner_valid = 1'b0;
      w_owner_data  = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_owner == c_PTR_W'(i)) begin
            w_owner_valid = REQ_VALID[i];
            w_owner_data  = REQ_DATA[8*i +: 8];
         end
      end
   end

   assign w_owner_inc = (r_owner == c_PTR_LAST) ? '0 : (r_owner + c_PTR_ONE);

   // Next-state, handshake and write-port decode
   always_comb begin
      w_state_nxt     = r_state;
      w_owner_nxt     = r_owner;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_grant_nxt     = r_grant;
      w_burst_cnt_nxt = r_burst_cnt;
      w_idle_cnt_nxt  = r_idle_cnt;
      w_tx_wrstb_nxt  = 1'b0;
      w_tx_data_nxt   = r_tx_data;
      REQ_READY       = '0;
      w_accept        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (|REQ_VALID) begin
               w_owner_nxt = w_pick;
               w_grant_nxt = c_GRANT_LSB << w_pick;
`ifdef UART_TX_ARB_TAG_EN
               w_state_nxt = S_TAG;
`else
               w_state_nxt = S_XFER;
`endif
            end
         end

         // Source tag write; only entered when tagging is compiled in
         S_TAG: begin
            if (!TX_FULL) begin
               w_tx_wrstb_nxt = 1'b1;
               w_tx_data_nxt  = TAG_BASE + 8'(r_owner);
               w_state_nxt    = S_XFER;
            end
         end

         S_XFER: begin
            REQ_READY = TX_FULL ? '0 : r_grant;
            w_accept  = w_owner_valid & ~TX_FULL;
            if (w_accept) begin
               w_tx_wrstb_nxt  = 1'b1;
               w_tx_data_nxt   = w_owner_data;
               w_idle_cnt_nxt  = '0;
               w_burst_cnt_nxt = r_burst_cnt + c_BCNT_ONE;
               if ((w_owner_data == EOL_CHAR) || (r_burst_cnt == c_BURST_LAST)) begin
                  w_state_nxt     = S_IDLE;
                  w_grant_nxt     = '0;
                  w_rr_ptr_nxt    = w_owner_inc;
                  w_burst_cnt_nxt = '0;
               end
            end else if (w_owner_valid) begin
               // Owner is ready to send but the FIFO is full: not idle
               w_idle_cnt_nxt = '0;
            end else if (r_idle_cnt >= c_IDLE_LAST) begin
               w_state_nxt     = S_IDLE;
               w_grant_nxt     = '0;
               w_rr_ptr_nxt    = w_owner_inc;
               w_burst_cnt_nxt = '0;
               w_idle_cnt_nxt  = '0;
            end else begin
               w_idle_cnt_nxt = r_idle_cnt + c_ICNT_ONE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   // State and datapath registers; reset drops any byte in flight
   always_ff @(posedge ACLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= S_IDLE;
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_burst_cnt <= '0;
         r_idle_cnt  <= '0;
         r_tx_wrstb  <= 1'b0;
         r_tx_data   <= 8'h00;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_grant     <= w_grant_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
         r_idle_cnt  <= w_idle_cnt_nxt;
         r_tx_wrstb  <= w_tx_wrstb_nxt;
         r_tx_data   <= w_tx_data_nxt;
      end
   end

   assign GRANT    = r_grant;
   assign BUSY     = (r_state != S_IDLE);
   assign TX_WRSTB = r_tx_wrstb;
   assign TX_DATA  = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                            |
// | Description : Scoreboard bench for uart_tx_arbiter (3 requesters, burst 4,  |
// |               idle timeout 8). Follows UART_TX_ARB_TAG_EN like the design.  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

   localparam int         N   = 3;
   localparam int         MB  = 4;
   localparam int         IT  = 8;
   localparam logic [7:0] EOL = 8'h0A;
   localparam logic [7:0] TGB = 8'h30;
`ifdef UART_TX_ARB_TAG_EN
   localparam bit TAG_EN = 1'b1;
`else
   localparam bit TAG_EN = 1'b0;
`endif

   logic           ACLK = 1'b0;
   logic           RESET_N = 1'b0;
   logic [N-1:0]   REQ_VALID = '0;
   logic [8*N-1:0] REQ_DATA = '0;
   logic [N-1:0]   REQ_READY;
   logic [N-1:0]   GRANT;
   logic           BUSY;
   logic           TX_WRSTB;
   logic [7:0]     TX_DATA;
   logic           TX_FULL = 1'b0;

   uart_tx_arbiter #(
      .NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(IT), .EOL_CHAR(EOL), .TAG_BASE(TGB)
   ) dut (
      .ACLK(ACLK), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
      .REQ_READY(REQ_READY), .GRANT(GRANT), .BUSY(BUSY), .TX_WRSTB(TX_WRSTB),
      .TX_DATA(TX_DATA), .TX_FULL(TX_FULL)
   );

   always #5 ACLK = ~ACLK;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] src_q [N][$];   // bytes each requester still has to offer
   logic [7:0] exp_q [N][$];   // bytes each requester still expects on TX
   int         gap [N];
   logic [N-1:0] acc;
   bit         full_mode = 1'b0;
   int         full_force = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_byte(input int r, input logic [7:0] b);
      src_q[r].push_back(b);
      exp_q[r].push_back(b);
   endtask

   task automatic push_str(input int r, input string s);
      for (int i = 0; i < s.len(); i++) push_byte(r, 8'(s[i]));
   endtask

   // Requester and FIFO-full drivers: handshake seen at negedge, new values #1 after posedge
   initial begin
      for (int i = 0; i < N; i++) gap[i] = 0;
      forever begin
         @(negedge ACLK);
         acc = RESET_N ? (REQ_VALID & REQ_READY) : '0;
         @(posedge ACLK);
         #1;
         for (int i = 0; i < N; i++) begin
            if (!RESET_N) begin
               src_q[i].delete();
               gap[i] = 0;
            end else if (acc[i]) begin
               void'(src_q[i].pop_front());
               gap[i] = $urandom_range(0, 2);
            end
            if (gap[i] > 0) begin
               gap[i]--;
               REQ_VALID[i] = 1'b0;
            end else if (src_q[i].size() > 0) begin
               REQ_VALID[i]        = 1'b1;
               REQ_DATA[8*i +: 8]  = src_q[i][0];
            end else begin
               REQ_VALID[i] = 1'b0;
            end
         end
         if (full_force > 0) begin
            TX_FULL = 1'b1;
            full_force--;
         end else begin
            TX_FULL = full_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
         end
      end
   end

   // Reference model and monitor: whole-burst arbitration rules applied at each negedge
   int           cur = -1;
   bit           in_x = 1'b0;
   bit           prev_x = 1'b0;
   int           lowcnt = 0;
   int           bn = 0;
   int           rr = 0;
   int           pick;
   bit           ending;
   logic [7:0]   eb;
   logic [N-1:0] vprev = '0;
   logic [N-1:0] oh;

   initial begin
      forever begin
         @(negedge ACLK);
         if (!RESET_N) begin
            check("rst_grant", 32'(GRANT), 0);
            check("rst_busy", 32'(BUSY), 0);
            check("rst_wrstb", 32'(TX_WRSTB), 0);
            check("rst_txdata", 32'(TX_DATA), 0);
            check("rst_ready", 32'(REQ_READY), 0);
            for (int i = 0; i < N; i++) exp_q[i].delete();
            cur = -1; in_x = 1'b0; prev_x = 1'b0; lowcnt = 0; bn = 0; rr = 0;
         end else begin
            if (prev_x) lowcnt = vprev[cur] ? 0 : lowcnt + 1;
            ending = 1'b0;
            if (TX_WRSTB) begin
               if (cur < 0) begin
                  check("stray_wrstb", 32'(TX_WRSTB), 0);
               end else if (!in_x) begin
                  check("tag_byte", 32'(TX_DATA), 32'(8'(TGB + 8'(cur))));
                  in_x = 1'b1;
               end else if (exp_q[cur].size() == 0) begin
                  check("extra_byte", 32'(TX_WRSTB), 0);
               end else begin
                  eb = exp_q[cur].pop_front();
                  check("tx_data", 32'(TX_DATA), 32'(eb));
                  bn++;
                  if (eb == EOL || bn == MB) ending = 1'b1;
               end
            end else if (prev_x && lowcnt == IT) begin
               ending = 1'b1;
            end

            if (ending) begin
               check("grant_release", 32'(GRANT), 0);
               cur = -1;
               in_x = 1'b0;
            end else if (cur >= 0) begin
               oh = '0; oh[cur] = 1'b1;
               check("grant_hold", 32'(GRANT), 32'(oh));
            end else begin
               pick = -1;
               for (int k = 0; k < N; k++)
                  if (pick < 0 && vprev[(rr + k) % N]) pick = (rr + k) % N;
               oh = '0;
               if (pick >= 0) oh[pick] = 1'b1;
               check("grant_new", 32'(GRANT), 32'(oh));
               if (pick >= 0) begin
                  cur = pick; rr = (pick + 1) % N; bn = 0; lowcnt = 0; in_x = !TAG_EN;
               end
            end

            oh = '0;
            if (cur >= 0 && in_x && !TX_FULL) oh[cur] = 1'b1;
            check("req_ready", 32'(REQ_READY), 32'(oh));
            check("busy", 32'(BUSY), 32'(cur >= 0));
            prev_x = (cur >= 0) && in_x;
         end
         vprev = REQ_VALID;
      end
   end

   task automatic drain(input string name);
      int cyc;
      bit empty;
      cyc = 0;
      do begin
         @(negedge ACLK);
         empty = !BUSY;
         for (int i = 0; i < N; i++)
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) empty = 1'b0;
         cyc++;
      end while (!empty && cyc < 3000);
      if (!empty) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_%s: still busy after %0d cycles, expected idle", name, cyc);
      end
      repeat (3) @(negedge ACLK);
   endtask

   task automatic wait_wrstb();
      int cyc;
      cyc = 0;
      do begin
         @(negedge ACLK);
         cyc++;
      end while (!TX_WRSTB && cyc < 200);
      if (!TX_WRSTB) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_wrstb: no write strobe in %0d cycles, expected one", cyc);
      end
   endtask

   logic [7:0] rb;
   int         rlen;
   int         rreq;

   initial begin
      repeat (3) @(negedge ACLK);
      #1 RESET_N = 1'b1;

      // Single line from requester 0
      push_str(0, "HI\n");
      drain("single");

      // Two requesters contending
      push_str(0, "AB\n");
      push_str(1, "CD\n");
      drain("contend");

      // FIFO full for 5 cycles in the middle of a burst
      push_str(2, "PQ\n");
      wait_wrstb();
      full_force = 5;
      drain("backpressure");

      // Burst limit then idle timeout on the unterminated remainder
      push_str(0, "abcdef");
      push_str(1, "Z\n");
      drain("limits");

      // Reset in the middle of a burst, then all requesters ask at once
      push_str(1, "long\n");
      push_str(2, "line\n");
      wait_wrstb();
      #2 RESET_N = 1'b0;
      #1;
      check("async_rst_grant", 32'(GRANT), 0);
      check("async_rst_wrstb", 32'(TX_WRSTB), 0);
      check("async_rst_busy", 32'(BUSY), 0);
      repeat (2) @(negedge ACLK);
      #1 RESET_N = 1'b1;
      push_str(2, "c\n");
      push_str(1, "b\n");
      push_str(0, "a\n");
      drain("post_reset");

      // Randomized traffic with random FIFO backpressure
      full_mode = 1'b1;
      repeat (40) begin
         rreq = $urandom_range(0, N - 1);
         rlen = $urandom_range(1, 7);
         for (int i = 0; i < rlen; i++) begin
            rb = ($urandom_range(0, 4) == 0) ? EOL : 8'(8'h41 + $urandom_range(0, 25));
            push_byte(rreq, rb);
         end
         repeat ($urandom_range(0, 15)) @(negedge ACLK);
      end
      drain("random");

      for (int i = 0; i < N; i++) check("leftover", 32'(exp_q[i].size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
